// File: rtl/ipad_fill_ctrl.sv
// Write-side controller for the PE input-pixel scratchpad: circular-buffer writes,
// fill accounting against datapath releases, and per-tile pixel budgeting.
module ipad_fill_ctrl #(
  parameter int DEPTH = 16,
  parameter int DWD   = 16,
  parameter int AWD   = $clog2(DEPTH),
  parameter int LWD   = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [LWD-1:0] i_tile_len,
  input  logic           i_flush,
  input  logic           i_ipix_valid,
  input  logic [DWD-1:0] i_ipix_data,
  output logic           o_ipix_ready,
  output logic           o_wen,
  output logic [AWD-1:0] o_waddr,
  output logic [DWD-1:0] o_wdata,
  input  logic           i_rel_valid,
  input  logic [AWD:0]   i_rel_cnt,
  output logic [AWD-1:0] o_rd_base,
  output logic [AWD:0]   o_avail_cnt,
  output logic           o_busy,
  output logic           o_tile_done,
  output logic           o_error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } state_t;

  localparam logic [AWD:0] FULL_CNT = (AWD + 1)'(DEPTH);

  state_t         state_q, state_d;
  logic [AWD-1:0] wptr_q, wptr_d;
  logic [AWD-1:0] base_q, base_d;
  logic [AWD:0]   avail_q, avail_d;
  logic [LWD-1:0] remain_q, remain_d;
  logic           error_q, error_d;
  logic           done_q, done_d;

  logic           ready;
  logic           accept;
  logic           rel_ok;
  logic [AWD:0]   rel_amt;

  // Ready depends only on registered fill; flush masks it so nothing is accepted while aborting.
  assign ready   = (state_q == ST_FILL) && (avail_q != FULL_CNT) && !i_flush;
  assign accept  = ready && i_ipix_valid;
  // Legality is judged against entries present before this cycle's write.
  assign rel_ok  = i_rel_valid && (i_rel_cnt != '0) && (i_rel_cnt <= avail_q);
  assign rel_amt = rel_ok ? i_rel_cnt : '0;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d  = state_q;
    wptr_d   = wptr_q;
    base_d   = base_q;
    avail_d  = avail_q;
    remain_d = remain_q;
    error_d  = error_q;
    done_d   = 1'b0;

    if (i_flush) begin
      state_d  = ST_IDLE;
      wptr_d   = '0;
      base_d   = '0;
      avail_d  = '0;
      remain_d = '0;
      error_d  = 1'b0;
    end else begin
      if (accept) begin
        wptr_d   = wptr_q + AWD'(1);
        remain_d = remain_q - LWD'(1);
      end
      avail_d = avail_q + (AWD + 1)'(accept) - rel_amt;
      // Low bits only: releasing DEPTH entries leaves the base where it was.
      if (rel_ok) base_d = base_q + i_rel_cnt[AWD-1:0];
      if (i_rel_valid && !rel_ok) error_d = 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (i_start && (i_tile_len != '0)) begin
            state_d  = ST_FILL;
            remain_d = i_tile_len;
          end
        end
        ST_FILL: begin
          if (accept && (remain_q == LWD'(1))) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (avail_d == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      wptr_q   <= '0;
      base_q   <= '0;
      avail_q  <= '0;
      remain_q <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      base_q   <= base_d;
      avail_q  <= avail_d;
      remain_q <= remain_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  assign o_ipix_ready = ready;
  assign o_wen        = accept;
  assign o_waddr      = wptr_q;
  assign o_wdata      = accept ? i_ipix_data : '0;
  assign o_rd_base    = base_q;
  assign o_avail_cnt  = avail_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_tile_done  = done_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_ipad_fill_ctrl.sv
// Directed bench for ipad_fill_ctrl: vector table for single-cycle behaviour, plus
// hand sequences for back-pressure/wrap, simultaneous accept+release, flush and reset.
module tb_ipad_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] tile_len;
  logic        flush;
  logic        ipix_valid;
  logic [15:0] ipix_data;
  logic        ipix_ready;
  logic        wen;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        rel_valid;
  logic [4:0]  rel_cnt;
  logic [3:0]  rd_base;
  logic [4:0]  avail_cnt;
  logic        busy;
  logic        tile_done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ipad_fill_ctrl #(.DEPTH(16), .DWD(16), .LWD(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_tile_len   (tile_len),
    .i_flush      (flush),
    .i_ipix_valid (ipix_valid),
    .i_ipix_data  (ipix_data),
    .o_ipix_ready (ipix_ready),
    .o_wen        (wen),
    .o_waddr      (waddr),
    .o_wdata      (wdata),
    .i_rel_valid  (rel_valid),
    .i_rel_cnt    (rel_cnt),
    .o_rd_base    (rd_base),
    .o_avail_cnt  (avail_cnt),
    .o_busy       (busy),
    .o_tile_done  (tile_done),
    .o_error      (error)
  );

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic        flush;
    logic        valid;
    logic [15:0] data;
    logic        rel;
    logic [4:0]  cnt;
    logic        rdy;
    logic        wen;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  base;
    logic [4:0]  avail;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(int st, int ln, int fl, int va, int da, int rl, int ct,
                              int rd, int we, int wa, int wd, int ba, int av,
                              int bu, int dn, int er);
    vec_t v;
    v.start = st[0];   v.len   = ln[15:0]; v.flush = fl[0]; v.valid = va[0];
    v.data  = da[15:0]; v.rel  = rl[0];    v.cnt   = ct[4:0];
    v.rdy   = rd[0];   v.wen   = we[0];    v.waddr = wa[3:0]; v.wdata = wd[15:0];
    v.base  = ba[3:0]; v.avail = av[4:0];  v.busy  = bu[0];   v.done  = dn[0];
    v.err   = er[0];
    return v;
  endfunction

  function automatic logic [63:0] obs();
    return {30'b0, ipix_ready, wen, waddr, wdata, rd_base, avail_cnt, busy, tile_done, error};
  endfunction

  function automatic logic [63:0] expv(vec_t v);
    return {30'b0, v.rdy, v.wen, v.waddr, v.wdata, v.base, v.avail, v.busy, v.done, v.err};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; tile_len = 0; flush = 0; ipix_valid = 0; ipix_data = 0;
    rel_valid = 0; rel_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic apply(vec_t v);
    start = v.start; tile_len = v.len; flush = v.flush; ipix_valid = v.valid;
    ipix_data = v.data; rel_valid = v.rel; rel_cnt = v.cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            st ln fl va data   rl ct  rdy wen wa wdata  ba av bu dn er
    vecs[0]  = mk(1, 5, 0, 0, 0,      0, 0,  0,  0,  0, 0,      0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 'hA001, 0, 0,  1,  1,  0, 'hA001, 0, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 'hA002, 0, 0,  1,  1,  1, 'hA002, 0, 1, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 'hA003, 1, 1,  1,  1,  2, 'hA003, 0, 2, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 'hA004, 1, 1,  1,  1,  3, 'hA004, 1, 2, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 'hA005, 1, 1,  1,  1,  4, 'hA005, 2, 2, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 'hA006, 1, 1,  0,  0,  5, 0,      3, 2, 1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0,      1, 1,  0,  0,  5, 0,      4, 1, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0,      0, 0,  0,  0,  5, 0,      5, 0, 0, 1, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0,      0, 0,  0,  0,  5, 0,      5, 0, 0, 0, 0);
    vecs[10] = mk(1, 3, 0, 0, 0,      0, 0,  0,  0,  5, 0,      5, 0, 0, 0, 0);
    vecs[11] = mk(1, 7, 0, 1, 'hA011, 0, 0,  1,  1,  5, 'hA011, 5, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 'hA012, 0, 0,  1,  1,  6, 'hA012, 5, 1, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0,      1, 3,  1,  0,  7, 0,      5, 2, 1, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0,      1, 0,  1,  0,  7, 0,      5, 2, 1, 0, 1);
    vecs[15] = mk(0, 0, 0, 1, 'hA015, 1, 2,  1,  1,  7, 'hA015, 5, 2, 1, 0, 1);
    vecs[16] = mk(1, 2, 0, 0, 0,      1, 1,  0,  0,  8, 0,      7, 1, 1, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0,      0, 0,  0,  0,  8, 0,      8, 0, 0, 1, 1);
    vecs[18] = mk(1, 2, 0, 0, 0,      0, 0,  0,  0,  8, 0,      8, 0, 0, 0, 1);
    vecs[19] = mk(0, 0, 1, 0, 0,      0, 0,  0,  0,  8, 0,      8, 0, 1, 0, 1);
    vecs[20] = mk(0, 0, 0, 0, 0,      1, 1,  0,  0,  0, 0,      0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 0, 0,      0, 0,  0,  0,  0, 0,      0, 0, 0, 0, 1);
    vecs[22] = mk(0, 0, 0, 0, 0,      0, 0,  0,  0,  0, 0,      0, 0, 0, 0, 0);

    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), obs(), expv(vecs[i]));
      tick();
    end

    // Simultaneous accept and release, then flush with accept and release pending.
    start = 1; tile_len = 14;
    tick();
    for (int k = 0; k < 5; k++) begin
      ipix_valid = 1; ipix_data = 16'hC000 + 16'(k);
      @(negedge clk);
      check($sformatf("sim_wr%0d", k), {wen, waddr}, {1'b1, 4'(k)});
      tick();
    end
    ipix_valid = 1; ipix_data = 16'hC005; rel_valid = 1; rel_cnt = 3;
    @(negedge clk);
    check("sim_pre", {wen, waddr, avail_cnt}, {1'b1, 4'd5, 5'd5});
    tick();
    for (int k = 0; k < 4; k++) begin
      ipix_valid = 1; ipix_data = 16'hC010 + 16'(k);
      @(negedge clk);
      if (k == 0) check("sim_post", {avail_cnt, rd_base}, {5'd3, 4'd3});
      check($sformatf("sim_fill%0d", k), {wen, waddr}, {1'b1, 4'(6 + k)});
      tick();
    end
    rel_valid = 1; rel_cnt = 15;
    @(negedge clk);
    check("pre_flush_avail", avail_cnt, 7);
    tick();
    flush = 1; ipix_valid = 1; ipix_data = 16'hDEAD; rel_valid = 1; rel_cnt = 1;
    @(negedge clk);
    check("flush_cycle", {ipix_ready, wen, avail_cnt, error}, {1'b0, 1'b0, 5'd7, 1'b1});
    tick();
    @(negedge clk);
    check("flush_after", obs(), 0);
    tick();
    @(negedge clk);
    check("flush_no_done", obs(), 0);

    // Fill to full with no release, reopen with a release of 4, finish the tile across the wrap.
    start = 1; tile_len = 20;
    tick();
    for (int k = 0; k < 17; k++) begin
      ipix_valid = 1; ipix_data = 16'hB000 + 16'(k);
      @(negedge clk);
      if (k < 16) check($sformatf("full_wr%0d", k), {wen, waddr}, {1'b1, 4'(k)});
      else        check("full_stall", {ipix_ready, wen, avail_cnt}, {1'b0, 1'b0, 5'd16});
      tick();
    end
    ipix_valid = 1; rel_valid = 1; rel_cnt = 4;
    @(negedge clk);
    check("full_rel_same_cycle", {ipix_ready, wen}, {1'b0, 1'b0});
    tick();
    for (int k = 0; k < 4; k++) begin
      ipix_valid = 1; ipix_data = 16'hB100 + 16'(k);
      @(negedge clk);
      if (k == 0) check("reopen", {ipix_ready, rd_base, avail_cnt}, {1'b1, 4'd4, 5'd12});
      check($sformatf("wrap_wr%0d", k), {wen, waddr, wdata}, {1'b1, 4'(k), 16'hB100 + 16'(k)});
      tick();
    end
    ipix_valid = 1; rel_valid = 1; rel_cnt = 16;
    @(negedge clk);
    check("drain_full", {ipix_ready, wen, busy, avail_cnt}, {1'b0, 1'b0, 1'b1, 5'd16});
    tick();
    @(negedge clk);
    check("drain_done", {tile_done, busy, rd_base, avail_cnt}, {1'b1, 1'b0, 4'd4, 5'd0});
    tick();
    @(negedge clk);
    check("done_pulse_end", tile_done, 0);

    // Synchronous reset mid-tile with error set.
    start = 1; tile_len = 5;
    tick();
    for (int k = 0; k < 2; k++) begin
      ipix_valid = 1; ipix_data = 16'hE000 + 16'(k);
      tick();
    end
    rel_valid = 1; rel_cnt = 7;
    tick();
    @(negedge clk);
    check("pre_reset", {error, avail_cnt, waddr, busy}, {1'b1, 5'd2, 4'd6, 1'b1});
    rst_n = 0; ipix_valid = 1; ipix_data = 16'hFFFF; rel_valid = 1; rel_cnt = 1;
    tick();
    rst_n = 1;
    @(negedge clk);
    check("post_reset", obs(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
